// File: rtl/speed_div_multi_pkg.sv
// Shared defaults, level encoding and request-operation type for the
// multi-speed clock divider.
package speed_div_multi_pkg;

    localparam int HALF_BASE_DEF  = 8;
    localparam int NUM_SPEEDS_DEF = 4;
    localparam int LVL_W_DEF      = 2;
    localparam int CNT_W_DEF      = 24;
    localparam int DEB_CYCLES_DEF = 4;

    localparam int SPD_SLOW = 0;

    typedef enum logic [1:0] {
        REQ_HOLD = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_UP   = 2'd2,
        REQ_DOWN = 2'd3
    } req_op_e;

    function automatic int spd_max(input int num_speeds);
        return num_speeds - 1;
    endfunction

endpackage

// File: rtl/speed_div_multi_if.sv
// Control/status bundle between the board-side requester and the divider.
interface speed_div_multi_if
    import speed_div_multi_pkg::*;
#(
    parameter int LVL_W = LVL_W_DEF
);
    logic             enable;
    logic             speed_up;
    logic             speed_down;
    logic             speed_load;
    logic [LVL_W-1:0] speed_val;
    logic             clk_out;
    logic             tick;
    logic [LVL_W-1:0] speed_level;
    logic             pending;

    modport master (
        output enable, speed_up, speed_down, speed_load, speed_val,
        input  clk_out, tick, speed_level, pending
    );

    modport slave (
        input  enable, speed_up, speed_down, speed_load, speed_val,
        output clk_out, tick, speed_level, pending
    );
endinterface

// File: rtl/speed_div_multi_btn_debounce.sv
// Raw button -> two-flop synchroniser -> debounce -> one-cycle press event.
module speed_div_multi_btn_debounce
    import speed_div_multi_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam int DC_W = $clog2(DEB_CYCLES + 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [DC_W-1:0] cnt_q, cnt_d;

    // The counter tracks consecutive samples that disagree with the accepted level.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == DC_W'(DEB_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + DC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/speed_div_multi.sv
// Multi-rate 50% clock divider; rate requests from buttons or a direct load
// are applied only at a half-period boundary so clk_out never glitches.
module speed_div_multi
    import speed_div_multi_pkg::*;
#(
    parameter int HALF_BASE  = HALF_BASE_DEF,
    parameter int NUM_SPEEDS = NUM_SPEEDS_DEF,
    parameter int LVL_W      = LVL_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int WRAP       = 1
) (
    input logic              clk,
    input logic              reset,
    speed_div_multi_if.slave bus
);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(spd_max(NUM_SPEEDS));
    localparam logic [LVL_W-1:0] LVL_SLOW = LVL_W'(SPD_SLOW);

    logic             up_ev, dn_ev;
    req_op_e          op;
    logic [LVL_W-1:0] req_q, req_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_m1;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;

    speed_div_multi_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.speed_up),
        .press   (up_ev)
    );

    speed_div_multi_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.speed_down),
        .press   (dn_ev)
    );

    // A load beats button events; simultaneous up and down cancel out.
    always_comb begin
        op = REQ_HOLD;
        if (bus.speed_load)         op = REQ_LOAD;
        else if (up_ev && !dn_ev)   op = REQ_UP;
        else if (dn_ev && !up_ev)   op = REQ_DOWN;
    end

    always_comb begin
        req_d = req_q;
        case (op)
            REQ_LOAD: req_d = (bus.speed_val > LVL_MAX) ? LVL_MAX : bus.speed_val;
            REQ_UP: begin
                if (req_q == LVL_MAX) req_d = (WRAP != 0) ? LVL_SLOW : LVL_MAX;
                else                  req_d = req_q + LVL_W'(1);
            end
            REQ_DOWN: begin
                if (req_q == LVL_SLOW) req_d = (WRAP != 0) ? LVL_MAX : LVL_SLOW;
                else                   req_d = req_q - LVL_W'(1);
            end
            default: req_d = req_q;
        endcase
    end

    // The applied level only moves at the end of a half-period.
    always_comb begin
        half_m1   = CNT_W'((HALF_BASE >> lvl_q) - 1);
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        lvl_d     = lvl_q;
        tick_d    = 1'b0;
        if (bus.enable) begin
            if (cnt_q == half_m1) begin
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
                lvl_d     = req_q;
                tick_d    = ~clk_out_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pending_d = (req_d != lvl_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q     <= LVL_SLOW;
            lvl_q     <= LVL_SLOW;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            req_q     <= req_d;
            lvl_q     <= lvl_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign bus.clk_out     = clk_out_q;
    assign bus.tick        = tick_q;
    assign bus.speed_level = lvl_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_speed_div_multi.sv
// Bench for speed_div_multi: wrapping and saturating instances driven in
// parallel and compared every cycle against a cycle-level behavioural model.
module tb_speed_div_multi;
    localparam int HB  = 8;
    localparam int NS  = 4;
    localparam int DEB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       up    = 1'b0;
    logic       dn    = 1'b0;
    logic       ld    = 1'b0;
    logic [1:0] val   = 2'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    speed_div_multi_if #(.LVL_W(2)) bus_w ();
    speed_div_multi_if #(.LVL_W(2)) bus_s ();

    assign bus_w.enable     = en;
    assign bus_w.speed_up   = up;
    assign bus_w.speed_down = dn;
    assign bus_w.speed_load = ld;
    assign bus_w.speed_val  = val;
    assign bus_s.enable     = en;
    assign bus_s.speed_up   = up;
    assign bus_s.speed_down = dn;
    assign bus_s.speed_load = ld;
    assign bus_s.speed_val  = val;

    speed_div_multi #(
        .HALF_BASE(HB), .NUM_SPEEDS(NS), .LVL_W(2), .CNT_W(24), .DEB_CYCLES(DEB), .WRAP(1)
    ) u_dut_wrap (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_w)
    );

    speed_div_multi #(
        .HALF_BASE(HB), .NUM_SPEEDS(NS), .LVL_W(2), .CNT_W(24), .DEB_CYCLES(DEB), .WRAP(0)
    ) u_dut_sat (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_s)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Index 0 = wrapping instance, 1 = saturating instance.
    int unsigned m_req[2];
    int unsigned m_lvl[2];
    int unsigned m_pos[2];
    bit          m_clk[2];
    bit          m_tick[2];
    bit          m_stab_up, m_stab_dn, m_ev_up, m_ev_dn;
    bit          q_up[$];
    bit          q_dn[$];

    // Synchronised samples are the raw values two edges old; a new level is
    // accepted once DEB of them in a row disagree with the current one.
    function automatic bit deb_next(input bit q[$], input bit stab);
        bit all_diff = 1'b1;
        for (int i = 2; i < DEB + 2; i++)
            if (q[i] == stab) all_diff = 1'b0;
        return all_diff ? ~stab : stab;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_req[v] = 0; m_lvl[v] = 0; m_pos[v] = 0; m_clk[v] = 0; m_tick[v] = 0;
        end
        m_stab_up = 0; m_stab_dn = 0; m_ev_up = 0; m_ev_dn = 0;
        q_up.delete();
        q_dn.delete();
        for (int i = 0; i < DEB + 2; i++) begin
            q_up.push_back(1'b0);
            q_dn.push_back(1'b0);
        end
    endtask

    task automatic model_edge();
        bit ns_up, ns_dn;
        for (int v = 0; v < 2; v++) begin
            int unsigned nreq = m_req[v];
            if (ld)
                nreq = (int'(val) > NS - 1) ? NS - 1 : int'(val);
            else if (m_ev_up && !m_ev_dn)
                nreq = (m_req[v] == NS - 1) ? ((v == 0) ? 0 : NS - 1) : m_req[v] + 1;
            else if (m_ev_dn && !m_ev_up)
                nreq = (m_req[v] == 0) ? ((v == 0) ? NS - 1 : 0) : m_req[v] - 1;
            m_tick[v] = 1'b0;
            if (en) begin
                m_pos[v]++;
                if (m_pos[v] == (HB >> m_lvl[v])) begin
                    m_pos[v]  = 0;
                    m_clk[v]  = !m_clk[v];
                    m_tick[v] = m_clk[v];
                    m_lvl[v]  = m_req[v];
                end
            end
            m_req[v] = nreq;
        end
        q_up.push_front(up);
        void'(q_up.pop_back());
        q_dn.push_front(dn);
        void'(q_dn.pop_back());
        ns_up = deb_next(q_up, m_stab_up);
        ns_dn = deb_next(q_dn, m_stab_dn);
        m_ev_up   = ns_up && !m_stab_up;
        m_ev_dn   = ns_dn && !m_stab_dn;
        m_stab_up = ns_up;
        m_stab_dn = ns_dn;
    endtask

    task automatic compare_all();
        chk("w_clk_out", int'(bus_w.clk_out), int'(m_clk[0]));
        chk("w_tick", int'(bus_w.tick), int'(m_tick[0]));
        chk("w_level", int'(bus_w.speed_level), int'(m_lvl[0]));
        chk("w_pending", int'(bus_w.pending), int'(m_req[0] != m_lvl[0]));
        chk("s_clk_out", int'(bus_s.clk_out), int'(m_clk[1]));
        chk("s_tick", int'(bus_s.tick), int'(m_tick[1]));
        chk("s_level", int'(bus_s.speed_level), int'(m_lvl[1]));
        chk("s_pending", int'(bus_s.pending), int'(m_req[1] != m_lvl[1]));
    endtask

    // Phase monitor on the wrapping instance's clk_out.
    int edge_n;
    bit prev_clk;
    int last_chg, last_phase, min_phase, tick_cnt;
    int rise_q[$];

    task automatic mon_clear();
        last_chg  = edge_n;
        min_phase = 1000;
        tick_cnt  = 0;
        rise_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        edge_n++;
        @(negedge clk);
        compare_all();
        if (bus_w.clk_out !== prev_clk) begin
            last_phase = edge_n - last_chg;
            last_chg   = edge_n;
            if (last_phase < min_phase) min_phase = last_phase;
            if (bus_w.clk_out) rise_q.push_back(edge_n);
            prev_clk = bus_w.clk_out;
        end
        if (bus_w.tick) tick_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called at a falling edge; reset lands asynchronously mid low phase.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        en = 0; up = 0; dn = 0; ld = 0; val = 0;
        model_reset();
        #1;
        chk({tag, "_w_clk_out"}, int'(bus_w.clk_out), 0);
        chk({tag, "_w_tick"}, int'(bus_w.tick), 0);
        chk({tag, "_w_level"}, int'(bus_w.speed_level), 0);
        chk({tag, "_w_pending"}, int'(bus_w.pending), 0);
        chk({tag, "_s_clk_out"}, int'(bus_s.clk_out), 0);
        chk({tag, "_s_level"}, int'(bus_s.speed_level), 0);
        chk({tag, "_s_pending"}, int'(bus_s.pending), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        edge_n   = 0;
        prev_clk = 1'b0;
        mon_clear();
    endtask

    task automatic press_up();
        up = 1'b1;
        steps(8);
        up = 1'b0;
        steps(8);
    endtask

    initial begin
        bit frozen;
        int waited;
        int hu, hd;

        edge_n = 0;
        @(negedge clk);
        do_reset("rst0");

        // Idle run at level 0.
        en = 1'b1;
        steps(48);
        chk("t1_first_rise", (rise_q.size() > 0) ? rise_q[0] : -1, 8);
        chk("t1_period", (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1, 16);
        chk("t1_ticks", tick_cnt, 3);
        chk("t1_level", int'(bus_w.speed_level), 0);

        // Held up button: request after 7 edges, clean rate change.
        min_phase = 1000;
        up = 1'b1;
        steps(6);
        chk("t2_pending_e6", int'(bus_w.pending), 0);
        step();
        chk("t2_pending_e7", int'(bus_w.pending), 1);
        steps(3);
        up = 1'b0;
        steps(40);
        chk("t2_min_phase_ok", int'(min_phase >= 4), 1);
        chk("t2_level", int'(bus_w.speed_level), 1);
        chk("t2_half", last_phase, 4);

        // Up to level 3 (clk/2), then one more press wraps or saturates.
        press_up();
        press_up();
        steps(20);
        chk("t3_w_level3", int'(bus_w.speed_level), 3);
        chk("t3_s_level3", int'(bus_s.speed_level), 3);
        chk("t3_half1", last_phase, 1);
        press_up();
        steps(20);
        chk("t3_w_wrap", int'(bus_w.speed_level), 0);
        chk("t3_s_hold", int'(bus_s.speed_level), 3);
        chk("t3_half8", last_phase, 8);

        // Two-cycle glitch must not register.
        up = 1'b1;
        steps(2);
        up = 1'b0;
        steps(12);
        chk("t4_level", int'(bus_w.speed_level), 0);
        chk("t4_pending", int'(bus_w.pending), 0);

        // Simultaneous up/down events cancel.
        up = 1'b1;
        dn = 1'b1;
        steps(8);
        up = 1'b0;
        dn = 1'b0;
        steps(8);
        chk("t5_w_level", int'(bus_w.speed_level), 0);
        chk("t5_w_pending", int'(bus_w.pending), 0);
        chk("t5_s_level", int'(bus_s.speed_level), 3);

        // Load while disabled, then resume.
        en = 1'b0;
        steps(3);
        frozen = bus_w.clk_out;
        ld  = 1'b1;
        val = 2'd2;
        step();
        ld = 1'b0;
        steps(5);
        chk("t6_frozen", int'(bus_w.clk_out), int'(frozen));
        chk("t6_pending", int'(bus_w.pending), 1);
        chk("t6_level_held", int'(bus_w.speed_level), 0);
        en = 1'b1;
        waited = 0;
        while (bus_w.speed_level != 2'd2 && waited < 40) begin
            step();
            waited++;
        end
        chk("t6_level2_in_time", int'(waited < 40), 1);
        steps(10);
        chk("t6_half2", last_phase, 2);
        ld  = 1'b1;
        val = 2'd1;
        step();
        ld = 1'b0;
        chk("t6_pending_before_rst", int'(bus_w.pending), 1);
        do_reset("t6_rst");

        // Randomised traffic against the model.
        hu = 0;
        hd = 0;
        for (int c = 0; c < 2500; c++) begin
            if (hu == 0) begin
                up = ($urandom_range(0, 2) == 0);
                hu = $urandom_range(1, 12);
            end
            if (hd == 0) begin
                dn = ($urandom_range(0, 2) == 0);
                hd = $urandom_range(1, 12);
            end
            hu--;
            hd--;
            en  = ($urandom_range(0, 9) != 0);
            ld  = ($urandom_range(0, 24) == 0);
            val = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
